btn_evt_ctrl: RTL and testbench

- Front-panel button controller for the aquarium monitor. Sits downstream of one sig_deb instance per button and upstream of the menu/settings logic.
- Turns N debounced button levels into discrete events: PRESS, RELEASE, LONG and auto-REPEAT.
- Per-button timing comes from a shared millisecond tick.
- Arbitrates events round-robin onto one valid/ready event channel.

---
 rtl/btn_evt_pkg.sv | 17 +
 rtl/btn_fsm.sv | 110 +++++++++++
 rtl/btn_evt_ctrl.sv | 135 +++++++++++++
 tb/tb_btn_evt_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_evt_pkg.sv
// Event kinds and per-button state encoding shared by the button event controller.
package btn_evt_pkg;

   typedef logic [1:0] evt_kind_t;

   localparam evt_kind_t EVT_PRESS   = 2'd0;
   localparam evt_kind_t EVT_RELEASE = 2'd1;
   localparam evt_kind_t EVT_LONG    = 2'd2;
   localparam evt_kind_t EVT_REPEAT  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_HELD    = 2'd2
   } btn_state_e;

endpackage

// File: rtl/btn_fsm.sv
// One button: press/long/repeat state machine, hold counter and a single pending event slot.
module btn_fsm
   import btn_evt_pkg::*;
#(
   parameter int LONG_MS = 1000,
   parameter int RPT_MS  = 200,
   parameter int CNT_W   = 10
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      btn_i,
   input  logic      tick_i,
   input  logic      grant_i,
   output logic      pend_valid_o,
   output evt_kind_t pend_kind_o,
   output logic      ovf_o
);

   btn_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pend_valid_q;
   evt_kind_t        pend_kind_q;
   logic             emit_s;
   evt_kind_t        kind_s;

   // Next-state and event decode; a release always wins over a same-cycle tick
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      emit_s  = 1'b0;
      kind_s  = EVT_PRESS;
      case (state_q)
         ST_IDLE: begin
            if (btn_i) begin
               state_d = ST_PRESSED;
               cnt_d   = '0;
               emit_s  = 1'b1;
               kind_s  = EVT_PRESS;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PRESSED: begin
            if (!btn_i) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               emit_s  = 1'b1;
               kind_s  = EVT_RELEASE;
            end else if (tick_i) begin
               if (cnt_q == CNT_W'(LONG_MS - 1)) begin
                  state_d = ST_HELD;
                  cnt_d   = '0;
                  emit_s  = 1'b1;
                  kind_s  = EVT_LONG;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         ST_HELD: begin
            if (!btn_i) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               emit_s  = 1'b1;
               kind_s  = EVT_RELEASE;
            end else if (tick_i) begin
               if (cnt_q == CNT_W'(RPT_MS - 1)) begin
                  cnt_d  = '0;
                  emit_s = 1'b1;
                  kind_s = EVT_REPEAT;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State, counter and pending slot; a new emit beats a same-edge grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         pend_valid_q <= 1'b0;
         pend_kind_q  <= EVT_PRESS;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (emit_s) begin
            pend_valid_q <= 1'b1;
            pend_kind_q  <= kind_s;
         end else if (grant_i) begin
            pend_valid_q <= 1'b0;
         end
      end
   end

   assign pend_valid_o = pend_valid_q;
   assign pend_kind_o  = pend_kind_q;
   assign ovf_o        = emit_s & pend_valid_q & ~grant_i;

endmodule

// File: rtl/btn_evt_ctrl.sv
// Front-panel button controller: ms prescaler, N button FSMs and a round-robin
// arbiter feeding one registered valid/ready event channel.
module btn_evt_ctrl
   import btn_evt_pkg::*;
#(
   parameter int N_BTN    = 4,
   parameter int TICK_DIV = 100000,
   parameter int LONG_MS  = 1000,
   parameter int RPT_MS   = 200
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_BTN-1:0]         btn_i,
   output logic                     evt_valid,
   input  logic                     evt_ready,
   output logic [$clog2(N_BTN)-1:0] evt_id,
   output logic [1:0]               evt_kind,
   output logic                     ovf_o
);

   localparam int IW    = $clog2(N_BTN);
   localparam int CMAX  = (LONG_MS > RPT_MS) ? LONG_MS : RPT_MS;
   localparam int CNT_W = ($clog2(CMAX) > 0) ? $clog2(CMAX) : 1;
   localparam int PW    = ($clog2(TICK_DIV) > 0) ? $clog2(TICK_DIV) : 1;

   logic [PW-1:0]    presc_q;
   logic             tick_s;
   logic [IW-1:0]    ptr_q;
   logic             evt_valid_q;
   logic [IW-1:0]    evt_id_q;
   evt_kind_t        evt_kind_q;
   logic             ovf_q;

   logic [N_BTN-1:0] pend_valid_s;
   evt_kind_t        pend_kind_s [N_BTN];
   logic [N_BTN-1:0] ovf_evt_s;
   logic [N_BTN-1:0] grant_s;
   logic             load_s;
   logic             found_s;
   logic [IW-1:0]    gnt_id_s;
   logic [IW-1:0]    ptr_nxt_s;
   logic [IW:0]      scan_s;

   assign tick_s = (presc_q == PW'(TICK_DIV - 1));

   // Free-running millisecond prescaler
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
      end else if (tick_s) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_q + PW'(1);
      end
   end

   for (genvar g = 0; g < N_BTN; g++) begin : g_btn
      btn_fsm #(
         .LONG_MS (LONG_MS),
         .RPT_MS  (RPT_MS),
         .CNT_W   (CNT_W)
      ) u_fsm (
         .clk          (clk),
         .rst_n        (rst_n),
         .btn_i        (btn_i[g]),
         .tick_i       (tick_s),
         .grant_i      (grant_s[g]),
         .pend_valid_o (pend_valid_s[g]),
         .pend_kind_o  (pend_kind_s[g]),
         .ovf_o        (ovf_evt_s[g])
      );
   end

   // Round-robin scan: first pending slot at or above the pointer, wrapping
   always_comb begin
      load_s    = ~evt_valid_q | evt_ready;
      found_s   = 1'b0;
      gnt_id_s  = '0;
      scan_s    = '0;
      for (int o = 0; o < N_BTN; o++) begin
         scan_s = {1'b0, ptr_q} + (IW+1)'(o);
         if (scan_s >= (IW+1)'(N_BTN)) begin
            scan_s = scan_s - (IW+1)'(N_BTN);
         end else begin
            scan_s = scan_s;
         end
         if (!found_s && pend_valid_s[scan_s[IW-1:0]]) begin
            found_s  = 1'b1;
            gnt_id_s = scan_s[IW-1:0];
         end else begin
            found_s = found_s;
         end
      end
      grant_s = '0;
      if (load_s && found_s) begin
         grant_s[gnt_id_s] = 1'b1;
      end else begin
         grant_s = '0;
      end
      if (gnt_id_s == IW'(N_BTN - 1)) begin
         ptr_nxt_s = '0;
      end else begin
         ptr_nxt_s = gnt_id_s + IW'(1);
      end
   end

   // Output register, pointer and overflow pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_valid_q <= 1'b0;
         evt_id_q    <= '0;
         evt_kind_q  <= EVT_PRESS;
         ptr_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         ovf_q <= |ovf_evt_s;
         if (load_s) begin
            if (found_s) begin
               evt_valid_q <= 1'b1;
               evt_id_q    <= gnt_id_s;
               evt_kind_q  <= pend_kind_s[gnt_id_s];
               ptr_q       <= ptr_nxt_s;
            end else begin
               evt_valid_q <= 1'b0;
            end
         end
      end
   end

   assign evt_valid = evt_valid_q;
   assign evt_id    = evt_id_q;
   assign evt_kind  = evt_kind_q;
   assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_btn_evt_ctrl.sv
// Self-checking bench for btn_evt_ctrl: directed scenarios plus randomized
// buttons/backpressure compared against an event-level reference model.
module tb_btn_evt_ctrl;

   localparam int N  = 4;
   localparam int TD = 4;
   localparam int L  = 3;
   localparam int R  = 2;
   localparam int K_PRESS = 0, K_RELEASE = 1, K_LONG = 2, K_REPEAT = 3;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] btn;
   logic         evt_valid;
   logic         evt_ready;
   logic [1:0]   evt_id;
   logic [1:0]   evt_kind;
   logic         ovf_o;

   int checks;
   int failures;

   // reference model state
   int m_presc, m_ptr, m_valid, m_id, m_kind, m_ovf;
   int m_pend [N];
   int m_down [N];
   int m_ticks[N];

   btn_evt_ctrl #(.N_BTN(N), .TICK_DIV(TD), .LONG_MS(L), .RPT_MS(R)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_i     (btn),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_id    (evt_id),
      .evt_kind  (evt_kind),
      .ovf_o     (ovf_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic m_reset();
      m_presc = 0; m_ptr = 0; m_valid = 0; m_id = 0; m_kind = 0; m_ovf = 0;
      for (int i = 0; i < N; i++) begin
         m_pend[i] = -1; m_down[i] = 0; m_ticks[i] = 0;
      end
   endtask

   // Advance one clock edge and update the model from the inputs seen at that edge.
   task automatic step();
      int tick, gnt, e, j;
      int old_pend[N];
      @(posedge clk);
      if (!rst_n) begin
         m_reset();
      end else begin
         tick = (m_presc == TD - 1) ? 1 : 0;
         m_presc = (m_presc + 1) % TD;
         old_pend = m_pend;
         gnt = -1;
         if (m_valid == 0 || evt_ready == 1'b1) begin
            m_valid = 0;
            for (int o = 0; o < N; o++) begin
               j = (m_ptr + o) % N;
               if (gnt < 0 && m_pend[j] >= 0) gnt = j;
            end
            if (gnt >= 0) begin
               m_valid = 1; m_id = gnt; m_kind = m_pend[gnt];
               m_pend[gnt] = -1; m_ptr = (gnt + 1) % N;
            end
         end
         m_ovf = 0;
         for (int i = 0; i < N; i++) begin
            e = -1;
            if (m_down[i] == 0) begin
               if (btn[i]) begin e = K_PRESS; m_down[i] = 1; m_ticks[i] = 0; end
            end else if (!btn[i]) begin
               e = K_RELEASE; m_down[i] = 0;
            end else if (tick == 1) begin
               m_ticks[i]++;
               if (m_ticks[i] == L) e = K_LONG;
               else if (m_ticks[i] > L && (m_ticks[i] - L) % R == 0) e = K_REPEAT;
            end
            if (e >= 0) begin
               if (old_pend[i] >= 0 && i != gnt) m_ovf = 1;
               m_pend[i] = e;
            end
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      btn = '0;
      m_reset();
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic drain(input int n);
      btn = '0;
      evt_ready = 1'b1;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; btn = '0; evt_ready = 1'b1;
      m_reset();
      #2;
      step();
      checks++;
      if (evt_valid !== 1'b0 || evt_id !== 2'd0 || evt_kind !== 2'd0 || ovf_o !== 1'b0) begin
         failures++;
         $display("FAIL reset: valid=%b id=%0d kind=%0d ovf=%b expected all 0", evt_valid, evt_id, evt_kind, ovf_o);
      end
   endtask

   task automatic test_press_release();
      do_reset();
      evt_ready = 1'b1;
      btn[0] = 1'b1;
      step();
      checks++;
      if (evt_valid !== 1'b0) begin
         failures++; $display("FAIL press_latency: valid=%b expected 0 at sampling edge", evt_valid);
      end
      step();
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_kind !== 2'(K_PRESS)) begin
         failures++; $display("FAIL press: valid=%b id=%0d kind=%0d expected 1/0/0", evt_valid, evt_id, evt_kind);
      end
      step();
      checks++;
      if (evt_valid !== 1'b0) begin
         failures++; $display("FAIL press_once: valid=%b expected 0", evt_valid);
      end
      btn[0] = 1'b0;
      step();
      step();
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_kind !== 2'(K_RELEASE)) begin
         failures++; $display("FAIL release: valid=%b id=%0d kind=%0d expected 1/0/1", evt_valid, evt_id, evt_kind);
      end
      step();
      checks++;
      if (evt_valid !== 1'b0) begin
         failures++; $display("FAIL release_once: valid=%b expected 0", evt_valid);
      end
   endtask

   task automatic test_long_hold();
      int ev_c[$], ev_k[$], ev_i[$];
      int n_long, n_rep, n_after, prev;
      do_reset();
      evt_ready = 1'b1;
      btn[2] = 1'b1;
      for (int c = 0; c < 40; c++) begin
         step();
         if (evt_valid === 1'b1) begin ev_c.push_back(c); ev_k.push_back(int'(evt_kind)); ev_i.push_back(int'(evt_id)); end
      end
      checks++;
      if (ev_c.size() < 2 || ev_k[0] != K_PRESS || ev_i[0] != 2) begin
         failures++; $display("FAIL long_first: events=%0d expected PRESS id 2 first", ev_c.size());
      end else begin
         n_long = 0; n_rep = 0;
         for (int i = 1; i < ev_c.size(); i++) begin
            if (ev_k[i] == K_LONG) n_long++;
            if (ev_k[i] == K_REPEAT) n_rep++;
         end
         checks++;
         if (ev_k[1] != K_LONG || n_long != 1 || ev_c[1] - ev_c[0] < 9 || ev_c[1] - ev_c[0] > 12) begin
            failures++; $display("FAIL long_timing: kind=%0d delta=%0d nlong=%0d expected LONG once at 9..12", ev_k[1], ev_c[1] - ev_c[0], n_long);
         end
         checks++;
         if (n_rep != 3) begin
            failures++; $display("FAIL repeat_count: got %0d expected 3", n_rep);
         end
         prev = ev_c[1];
         for (int i = 2; i < ev_c.size(); i++) begin
            checks++;
            if (ev_k[i] != K_REPEAT || ev_i[i] != 2 || ev_c[i] - prev != 8) begin
               failures++; $display("FAIL repeat_period: kind=%0d id=%0d delta=%0d expected REPEAT id 2 delta 8", ev_k[i], ev_i[i], ev_c[i] - prev);
            end
            prev = ev_c[i];
         end
      end
      btn[2] = 1'b0;
      n_after = 0;
      for (int c = 0; c < 30; c++) begin
         step();
         if (evt_valid === 1'b1) begin
            n_after++;
            checks++;
            if (evt_kind !== 2'(K_RELEASE) || evt_id !== 2'd2) begin
               failures++; $display("FAIL after_release: kind=%0d id=%0d expected RELEASE id 2", evt_kind, evt_id);
            end
         end
      end
      checks++;
      if (n_after != 1) begin
         failures++; $display("FAIL release_count: got %0d expected 1", n_after);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      evt_ready = 1'b0;
      btn[1] = 1'b1;
      step();
      for (int c = 0; c < 10; c++) begin
         step();
         checks++;
         if (evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_kind !== 2'(K_PRESS)) begin
            failures++; $display("FAIL hold_stable: cyc=%0d valid=%b id=%0d kind=%0d expected 1/1/0", c, evt_valid, evt_id, evt_kind);
         end
      end
      evt_ready = 1'b1;
      step();
      checks++;
      if (evt_valid !== 1'b0) begin
         failures++; $display("FAIL accept: valid=%b expected 0", evt_valid);
      end
      step();
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_kind !== 2'(K_LONG)) begin
         failures++; $display("FAIL bp_long: valid=%b id=%0d kind=%0d expected 1/1/2", evt_valid, evt_id, evt_kind);
      end
      drain(4);
   endtask

   task automatic test_fairness();
      do_reset();
      evt_ready = 1'b1;
      btn[1] = 1'b1; btn[3] = 1'b1;
      step();
      step();
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_kind !== 2'(K_PRESS)) begin
         failures++; $display("FAIL rr_first: valid=%b id=%0d kind=%0d expected 1/1/0", evt_valid, evt_id, evt_kind);
      end
      step();
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd3 || evt_kind !== 2'(K_PRESS)) begin
         failures++; $display("FAIL rr_second: valid=%b id=%0d kind=%0d expected 1/3/0", evt_valid, evt_id, evt_kind);
      end
      btn[3] = 1'b0; btn[0] = 1'b1;
      step();
      step();
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_kind !== 2'(K_PRESS)) begin
         failures++; $display("FAIL rr_wrap_first: valid=%b id=%0d kind=%0d expected 1/0/0", evt_valid, evt_id, evt_kind);
      end
      step();
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd3 || evt_kind !== 2'(K_RELEASE) || ovf_o !== 1'b0) begin
         failures++; $display("FAIL rr_wrap_second: valid=%b id=%0d kind=%0d ovf=%b expected 1/3/1/0", evt_valid, evt_id, evt_kind, ovf_o);
      end
      drain(4);
   endtask

   task automatic test_overflow();
      do_reset();
      evt_ready = 1'b0;
      btn[0] = 1'b1;
      step();
      step();
      btn[0] = 1'b0;
      step();
      checks++;
      if (ovf_o !== 1'b0) begin
         failures++; $display("FAIL ovf_early: ovf=%b expected 0", ovf_o);
      end
      btn[0] = 1'b1;
      step();
      checks++;
      if (ovf_o !== 1'b1 || evt_valid !== 1'b1 || evt_kind !== 2'(K_PRESS)) begin
         failures++; $display("FAIL ovf_pulse: ovf=%b valid=%b kind=%0d expected 1/1/0", ovf_o, evt_valid, evt_kind);
      end
      step();
      checks++;
      if (ovf_o !== 1'b0) begin
         failures++; $display("FAIL ovf_once: ovf=%b expected 0", ovf_o);
      end
      evt_ready = 1'b1;
      step();
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_kind !== 2'(K_PRESS)) begin
         failures++; $display("FAIL ovf_slot: valid=%b id=%0d kind=%0d expected 1/0/0", evt_valid, evt_id, evt_kind);
      end
      step();
      checks++;
      if (evt_valid !== 1'b0) begin
         failures++; $display("FAIL ovf_drained: valid=%b expected 0", evt_valid);
      end
      drain(4);
   endtask

   task automatic test_reset_mid_hold();
      do_reset();
      evt_ready = 1'b0;
      btn[2] = 1'b1;
      for (int c = 0; c < 20; c++) step();
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin
         failures++; $display("FAIL pre_reset: valid=%b id=%0d expected 1/2", evt_valid, evt_id);
      end
      #2;
      rst_n = 1'b0;
      m_reset();
      #1;
      checks++;
      if (evt_valid !== 1'b0 || evt_id !== 2'd0 || evt_kind !== 2'd0 || ovf_o !== 1'b0) begin
         failures++; $display("FAIL async_reset: valid=%b id=%0d kind=%0d ovf=%b expected all 0", evt_valid, evt_id, evt_kind, ovf_o);
      end
      step();
      rst_n = 1'b1;
      step();
      step();
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd2 || evt_kind !== 2'(K_PRESS)) begin
         failures++; $display("FAIL press_after_reset: valid=%b id=%0d kind=%0d expected 1/2/0", evt_valid, evt_id, evt_kind);
      end
      drain(4);
   endtask

   task automatic test_random();
      do_reset();
      evt_ready = 1'b1;
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 15) == 0) btn[i] = ~btn[i];
         end
         evt_ready = ($urandom_range(0, 3) != 0);
         step();
         checks++;
         if (evt_valid !== (m_valid != 0)) begin
            failures++; $display("FAIL rand_valid: cyc=%0d got %b expected %0d", c, evt_valid, m_valid);
         end else if (m_valid != 0) begin
            checks++;
            if (evt_id !== 2'(m_id) || evt_kind !== 2'(m_kind)) begin
               failures++; $display("FAIL rand_evt: cyc=%0d id=%0d kind=%0d expected id=%0d kind=%0d", c, evt_id, evt_kind, m_id, m_kind);
            end
         end
         checks++;
         if (ovf_o !== (m_ovf != 0)) begin
            failures++; $display("FAIL rand_ovf: cyc=%0d got %b expected %0d", c, ovf_o, m_ovf);
         end
      end
      drain(4);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      btn = '0;
      evt_ready = 1'b1;
      test_reset();
      test_press_release();
      test_long_hold();
      test_backpressure();
      test_fairness();
      test_overflow();
      test_reset_mid_hold();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
